// File: rtl/disparity_row_scheduler.sv
// disparity_row_scheduler: walks the single-SAD disparity core across one buffered row.
// Per column: reset the core, pulse start with the column index, wait for done, then hand
// the disparity to the depth-map writer on a valid/ready stream.
// Optional feature macro: DISP_SCHED_TIMEOUT_EN adds a WAIT watchdog that emits an error
// beat (data 0, disp_err=1) after TIMEOUT cycles without core_done.
module disparity_row_scheduler #(
  parameter int unsigned DISP_BITS = 6,
  parameter int unsigned COL_BITS  = 6,
  parameter int unsigned NUM_COLS  = 50,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 row_valid,
  output logic                 row_ack,
  output logic                 busy,
  output logic                 core_rst,
  output logic                 core_start,
  output logic [COL_BITS-1:0]  core_col,
  input  logic                 core_done,
  input  logic [DISP_BITS-1:0] core_disp,
  output logic                 disp_valid,
  input  logic                 disp_ready,
  output logic [DISP_BITS-1:0] disp_data,
  output logic [COL_BITS-1:0]  disp_col,
  output logic                 disp_last,
  output logic                 disp_err
);

  localparam logic [COL_BITS-1:0] LastCol = COL_BITS'(NUM_COLS - 1);

  typedef enum logic [2:0] {StIdle, StClear, StStart, StWait, StEmit} state_e;

  state_e               state_q, state_d;
  logic                 row_ack_q, row_ack_d;
  logic                 busy_q, busy_d;
  logic                 core_start_q, core_start_d;
  // core_col doubles as the row's column counter; it only moves on CLEAR entry.
  logic [COL_BITS-1:0]  core_col_q, core_col_d;
  logic                 disp_valid_q, disp_valid_d;
  logic [DISP_BITS-1:0] disp_data_q, disp_data_d;
  logic [COL_BITS-1:0]  disp_col_q, disp_col_d;
  logic                 disp_last_q, disp_last_d;

`ifdef DISP_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            disp_err_q, disp_err_d;

  // Watchdog counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q      <= '0;
      disp_err_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      disp_err_q <= disp_err_d;
    end
  end

  assign disp_err = disp_err_q;
`else
  assign disp_err = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    row_ack_d    = 1'b0;
    busy_d       = busy_q;
    core_start_d = 1'b0;
    core_col_d   = core_col_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    disp_col_d   = disp_col_q;
    disp_last_d  = disp_last_q;
`ifdef DISP_SCHED_TIMEOUT_EN
    tmo_d        = tmo_q;
    disp_err_d   = disp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (row_valid) begin
          row_ack_d  = 1'b1;
          busy_d     = 1'b1;
          core_col_d = '0;
          state_d    = StClear;
        end
      end
      StClear: begin
        core_start_d = 1'b1;
        state_d      = StStart;
      end
      StStart: begin
`ifdef DISP_SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (core_done) begin
          disp_valid_d = 1'b1;
          disp_data_d  = core_disp;
          disp_col_d   = core_col_q;
          disp_last_d  = (core_col_q == LastCol);
`ifdef DISP_SCHED_TIMEOUT_EN
          disp_err_d   = 1'b0;
`endif
          state_d      = StEmit;
        end
`ifdef DISP_SCHED_TIMEOUT_EN
        else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          disp_valid_d = 1'b1;
          disp_data_d  = '0;
          disp_col_d   = core_col_q;
          disp_last_d  = (core_col_q == LastCol);
          disp_err_d   = 1'b1;
          state_d      = StEmit;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      StEmit: begin
        if (disp_ready) begin
          disp_valid_d = 1'b0;
          if (disp_last_q) begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            core_col_d = core_col_q + 1'b1;
            state_d    = StClear;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      row_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_col_q   <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      disp_col_q   <= '0;
      disp_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_ack_q    <= row_ack_d;
      busy_q       <= busy_d;
      core_start_q <= core_start_d;
      core_col_q   <= core_col_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      disp_col_q   <= disp_col_d;
      disp_last_q  <= disp_last_d;
    end
  end

  // Core reset follows the system reset so the core is held while we are.
  assign core_rst   = rst | (state_q == StClear);
  assign row_ack    = row_ack_q;
  assign busy       = busy_q;
  assign core_start = core_start_q;
  assign core_col   = core_col_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign disp_col   = disp_col_q;
  assign disp_last  = disp_last_q;

endmodule
